// File: rtl/ram_arb_pkg.sv
// Shared opcode constants, FSM state type and opcode helpers for the RAM
// command arbiter.
package ram_arb_pkg;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_WAIT,
    S_RESP
  } arb_state_e;

  function automatic logic [1:0] addr_opcode(input logic wr);
    return wr ? OP_WR_ADDR : OP_RD_ADDR;
  endfunction

  function automatic logic [1:0] data_opcode(input logic wr);
    return wr ? OP_WR_DATA : OP_RD_DATA;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: priority starts one past the last granted requester
// and wraps; the last-grant pointer moves only when a grant is taken.
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic                       advance,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] last_grant;

  // NOTE: every variable written here gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    int  cand;
    logic found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last_grant) + k) % NUM_REQ;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= IDX_W'(NUM_REQ - 1);
    end else if (advance && (|req)) begin
      last_grant <= grant_idx;
    end
  end

endmodule

// File: rtl/ram_cmd_arbiter.sv
// Shares one RAM command port among NUM_REQ requesters, expanding each
// transaction into an address/data command pair and returning read replies.
module ram_cmd_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int MEM_WIDTH   = 8,
  parameter int ADDR_SIZE   = 8,
  parameter int RSP_TIMEOUT = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_wr,
  input  logic [NUM_REQ*ADDR_SIZE-1:0]   req_addr,
  input  logic [NUM_REQ*MEM_WIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0]     rsp_id,
  output logic [MEM_WIDTH-1:0]           rsp_data,
  output logic                           rsp_err,
  output logic [MEM_WIDTH+1:0]           rx_data,
  output logic                           rx_valid,
  input  logic [MEM_WIDTH-1:0]           tx_data,
  input  logic                           tx_valid
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(RSP_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RSP_TIMEOUT - 1);

  arb_state_e           state;
  logic [NUM_REQ-1:0]   grant;
  logic [ID_W-1:0]      grant_idx;
  logic                 in_idle;
  logic                 sel_wr;
  logic [ADDR_SIZE-1:0] sel_addr;
  logic [MEM_WIDTH-1:0] sel_wdata;

  logic                 lat_wr;
  logic [MEM_WIDTH-1:0] lat_wdata;
  logic [ID_W-1:0]      lat_id;
  logic [CNT_W-1:0]     wait_cnt;

  // Grants are only offered while idle and out of reset.
  assign in_idle   = (state == S_IDLE) && !rst;
  assign req_ready = in_idle ? grant : '0;

  assign sel_wr    = req_wr[grant_idx];
  assign sel_addr  = req_addr[ADDR_SIZE*int'(grant_idx) +: ADDR_SIZE];
  assign sel_wdata = req_wdata[MEM_WIDTH*int'(grant_idx) +: MEM_WIDTH];

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .advance   (in_idle),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      rx_valid  <= 1'b0;
      rx_data   <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      lat_wr    <= 1'b0;
      lat_wdata <= '0;
      lat_id    <= '0;
      wait_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|req_valid) begin
            // The address command is loaded straight from the granted
            // request so it appears on the pins the cycle after the grant.
            lat_wr    <= sel_wr;
            lat_wdata <= sel_wdata;
            lat_id    <= grant_idx;
            rx_valid  <= 1'b1;
            rx_data   <= {addr_opcode(sel_wr), sel_addr};
            state     <= S_ADDR;
          end
        end

        S_ADDR: begin
          rx_valid <= 1'b1;
          rx_data  <= {data_opcode(lat_wr), (lat_wr ? lat_wdata : '0)};
          state    <= S_DATA;
        end

        S_DATA: begin
          rx_valid <= 1'b0;
          rx_data  <= '0;
          wait_cnt <= '0;
          state    <= lat_wr ? S_IDLE : S_WAIT;
        end

        S_WAIT: begin
          // A reply in the final timeout cycle still wins over the error.
          if (tx_valid) begin
            rsp_valid <= 1'b1;
            rsp_id    <= lat_id;
            rsp_data  <= tx_data;
            rsp_err   <= 1'b0;
            state     <= S_RESP;
          end else if (wait_cnt == CNT_LAST) begin
            rsp_valid <= 1'b1;
            rsp_id    <= lat_id;
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            state     <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        S_RESP: begin
          rsp_valid <= 1'b0;
          rsp_id    <= '0;
          rsp_data  <= '0;
          rsp_err   <= 1'b0;
          state     <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_cmd_arbiter.sv
// Self-checking bench for ram_cmd_arbiter: directed vector table, hand-built
// corner sequences, and randomized traffic against a transaction-level model.
module tb_ram_cmd_arbiter;

  localparam int N = 2;
  localparam int W = 8;
  localparam int T = 16;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_wr;
  logic [N*W-1:0] req_addr;
  logic [N*W-1:0] req_wdata;
  logic [N-1:0]   req_ready;
  logic           rsp_valid;
  logic [0:0]     rsp_id;
  logic [W-1:0]   rsp_data;
  logic           rsp_err;
  logic [W+1:0]   rx_data;
  logic           rx_valid;
  logic [W-1:0]   tx_data;
  logic           tx_valid;

  int n_vec;
  int n_bad;

  ram_cmd_arbiter #(
    .NUM_REQ     (N),
    .MEM_WIDTH   (W),
    .ADDR_SIZE   (W),
    .RSP_TIMEOUT (T)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    req_wr = '0;
    tx_valid = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  // Directed vector record: one entry per clock cycle.
  typedef struct {
    logic [1:0] rv;
    logic [1:0] wr;
    logic [7:0] a0, a1, d0, d1;
    logic       tv;
    logic [7:0] td;
    logic [1:0] e_ready;
    logic       e_rxv;
    logic [9:0] e_rx;
    logic       e_rspv;
    logic       e_id;
    logic [7:0] e_data;
    logic       e_err;
  } vec_t;

  // Model's view of one future cycle.
  typedef struct {
    logic       rxv;
    logic [9:0] rx;
    logic       rspv;
    logic       id;
    logic [7:0] data;
    logic       err;
    logic       wait_c;
    logic       tx_now;
    logic [7:0] txd;
  } exp_t;

  function automatic int rr_pick(input logic [N-1:0] rv, input int last);
    for (int k = 1; k <= N; k++) begin
      if (rv[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  vec_t tbl[9];
  exp_t q[$];

  initial begin
    n_vec = 0;
    n_bad = 0;
    req_addr = '0;
    req_wdata = '0;
    tx_data = '0;
    do_reset();

    // Reset state.
    @(negedge clk);
    check("reset req_ready", 32'(req_ready), 0);
    check("reset rx_valid", 32'(rx_valid), 0);
    check("reset rx_data", 32'(rx_data), 0);
    check("reset rsp_valid", 32'(rsp_valid), 0);
    check("reset rsp_data", 32'(rsp_data), 0);
    check("reset rsp_err", 32'(rsp_err), 0);
    tick();

    // Write 0xA5 to 0x12 from req0, then read it back from req1, with stray
    // tx_valid pulses in IDLE and ADDR that must be ignored.
    tbl[0] = '{2'b01, 2'b01, 8'h12, 8'h00, 8'hA5, 8'h00, 1'b1, 8'h5A, 2'b01, 1'b0, 10'h000, 1'b0, 1'b0, 8'h00, 1'b0};
    tbl[1] = '{2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 8'h5A, 2'b00, 1'b1, 10'h012, 1'b0, 1'b0, 8'h00, 1'b0};
    tbl[2] = '{2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 2'b00, 1'b1, 10'h1A5, 1'b0, 1'b0, 8'h00, 1'b0};
    tbl[3] = '{2'b10, 2'b00, 8'h00, 8'h12, 8'h00, 8'h00, 1'b1, 8'h3C, 2'b10, 1'b0, 10'h000, 1'b0, 1'b0, 8'h00, 1'b0};
    tbl[4] = '{2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 8'h3C, 2'b00, 1'b1, 10'h212, 1'b0, 1'b0, 8'h00, 1'b0};
    tbl[5] = '{2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 2'b00, 1'b1, 10'h300, 1'b0, 1'b0, 8'h00, 1'b0};
    tbl[6] = '{2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 8'hA5, 2'b00, 1'b0, 10'h000, 1'b0, 1'b0, 8'h00, 1'b0};
    tbl[7] = '{2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 2'b00, 1'b0, 10'h000, 1'b1, 1'b1, 8'hA5, 1'b0};
    tbl[8] = '{2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 2'b00, 1'b0, 10'h000, 1'b0, 1'b0, 8'h00, 1'b0};
    for (int i = 0; i < 9; i++) begin
      req_valid = tbl[i].rv;
      req_wr    = tbl[i].wr;
      req_addr  = {tbl[i].a1, tbl[i].a0};
      req_wdata = {tbl[i].d1, tbl[i].d0};
      tx_valid  = tbl[i].tv;
      tx_data   = tbl[i].td;
      @(negedge clk);
      check($sformatf("tbl[%0d] req_ready", i), 32'(req_ready), 32'(tbl[i].e_ready));
      check($sformatf("tbl[%0d] rx_valid", i), 32'(rx_valid), 32'(tbl[i].e_rxv));
      if (tbl[i].e_rxv) check($sformatf("tbl[%0d] rx_data", i), 32'(rx_data), 32'(tbl[i].e_rx));
      check($sformatf("tbl[%0d] rsp_valid", i), 32'(rsp_valid), 32'(tbl[i].e_rspv));
      if (tbl[i].e_rspv) begin
        check($sformatf("tbl[%0d] rsp_id", i), 32'(rsp_id), 32'(tbl[i].e_id));
        check($sformatf("tbl[%0d] rsp_data", i), 32'(rsp_data), 32'(tbl[i].e_data));
        check($sformatf("tbl[%0d] rsp_err", i), 32'(rsp_err), 32'(tbl[i].e_err));
      end
      tick();
    end

    // Both requesters writing continuously: grants alternate 0,1,0,1 every 3 cycles.
    req_valid = 2'b11;
    req_wr    = 2'b11;
    req_addr  = {8'hB1, 8'hA0};
    req_wdata = {8'h22, 8'h11};
    tx_valid  = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c % 3 == 0)
        check($sformatf("alt grant c%0d", c), 32'(req_ready), ((c / 3) % 2 == 0) ? 32'h1 : 32'h2);
      else
        check($sformatf("alt busy c%0d", c), 32'(req_ready), 0);
      if (c % 3 == 1)
        check($sformatf("alt addr cmd c%0d", c), 32'(rx_data), ((c / 3) % 2 == 0) ? 32'h0A0 : 32'h0B1);
      tick();
    end

    // Read timeout: response with error in cycle 3+T, idle right after.
    req_valid = 2'b10;
    req_wr    = 2'b00;
    req_addr  = {8'h77, 8'h00};
    for (int c = 0; c <= T + 4; c++) begin
      @(negedge clk);
      if (c == 0) check("tmo grant", 32'(req_ready), 32'h2);
      if (c == 1) check("tmo addr cmd", 32'(rx_data), 32'h277);
      if (c == 2) check("tmo data cmd", 32'(rx_data), 32'h300);
      if (c >= 1 && c < T + 3) check($sformatf("tmo quiet c%0d", c), 32'(rsp_valid), 0);
      if (c == T + 3) begin
        check("tmo rsp_valid", 32'(rsp_valid), 1);
        check("tmo rsp_err", 32'(rsp_err), 1);
        check("tmo rsp_data", 32'(rsp_data), 0);
        check("tmo rsp_id", 32'(rsp_id), 1);
      end
      if (c == T + 4) begin
        check("tmo rsp done", 32'(rsp_valid), 0);
        check("tmo idle grant", 32'(req_ready), 32'h1);
      end
      tick();
      req_valid = (c + 1 == T + 4) ? 2'b01 : 2'b00;
      req_wr    = 2'b01;
    end
    req_valid = 2'b00;
    repeat (3) tick();

    // Reset while waiting for a read reply.
    req_valid = 2'b10;
    req_wr    = 2'b00;
    for (int c = 0; c < 11; c++) begin
      rst = (c == 4);
      if (c == 5) begin
        req_valid = 2'b11;
        req_wr    = 2'b11;
      end else if (c != 0) begin
        req_valid = 2'b00;
      end
      @(negedge clk);
      if (c == 0) check("rst grant", 32'(req_ready), 32'h2);
      if (c == 5) begin
        check("rst rx_valid", 32'(rx_valid), 0);
        check("rst rx_data", 32'(rx_data), 0);
        check("rst rsp_valid", 32'(rsp_valid), 0);
        check("rst rsp_data", 32'(rsp_data), 0);
        check("rst rsp_err", 32'(rsp_err), 0);
        check("rst regrant req0", 32'(req_ready), 32'h1);
      end
      if (c > 5) check($sformatf("rst no rsp c%0d", c), 32'(rsp_valid), 0);
      tick();
    end
    rst = 1'b0;

    // Randomized traffic against the transaction-level model.
    do_reset();
    begin
      int   last;
      exp_t cur;
      exp_t e;
      logic [N-1:0] exp_ready;
      int   g;
      last = N - 1;
      q.delete();
      for (int cyc = 0; cyc < 4000; cyc++) begin
        req_valid = N'($urandom);
        req_wr    = N'($urandom);
        req_addr  = (N*W)'($urandom);
        req_wdata = (N*W)'($urandom);
        cur = '{default: '0};
        if (q.size() > 0) cur = q[0];
        if (cur.wait_c) begin
          tx_valid = cur.tx_now;
          tx_data  = cur.tx_now ? cur.txd : W'($urandom);
        end else begin
          tx_valid = ($urandom_range(0, 3) == 0);
          tx_data  = W'($urandom);
        end
        g = (q.size() == 0) ? rr_pick(req_valid, last) : -1;
        exp_ready = (g >= 0) ? N'(1 << g) : '0;
        @(negedge clk);
        check("rnd req_ready", 32'(req_ready), 32'(exp_ready));
        check("rnd rx_valid", 32'(rx_valid), 32'(cur.rxv));
        if (cur.rxv) check("rnd rx_data", 32'(rx_data), 32'(cur.rx));
        check("rnd rsp_valid", 32'(rsp_valid), 32'(cur.rspv));
        if (cur.rspv) begin
          check("rnd rsp_id", 32'(rsp_id), 32'(cur.id));
          check("rnd rsp_data", 32'(rsp_data), 32'(cur.data));
          check("rnd rsp_err", 32'(rsp_err), 32'(cur.err));
        end
        if (q.size() > 0) begin
          void'(q.pop_front());
        end else if (g >= 0) begin
          logic       wr;
          logic [7:0] ad;
          logic [7:0] wd;
          int         k;
          logic [7:0] rd;
          last = g;
          wr = req_wr[g];
          ad = req_addr[g*W +: W];
          wd = req_wdata[g*W +: W];
          e = '{default: '0};
          e.rxv = 1'b1;
          e.rx  = {(wr ? 2'b00 : 2'b10), ad};
          q.push_back(e);
          e.rx  = wr ? {2'b01, wd} : {2'b11, 8'h00};
          q.push_back(e);
          if (!wr) begin
            k  = $urandom_range(0, T + 3);
            rd = W'($urandom);
            e = '{default: '0};
            e.wait_c = 1'b1;
            for (int j = 0; j < ((k < T) ? k + 1 : T); j++) begin
              e.tx_now = (k < T) && (j == k);
              e.txd    = rd;
              q.push_back(e);
            end
            e = '{default: '0};
            e.rspv = 1'b1;
            e.id   = g[0];
            e.data = (k < T) ? rd : 8'h00;
            e.err  = (k >= T);
            q.push_back(e);
          end
        end
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_cmd_arbiter.md
# ram_cmd_arbiter

Shares the single SPI-side RAM command port between `NUM_REQ` requesters. Accepts whole write/read transactions and expands each into the two-command opcode sequence the RAM expects: write-address then write-data, or read-address then read-data. Captures the RAM's read reply and returns it to the owning requester. Sits between the requester fabric and the RAM's `rx_data`/`rx_valid`/`tx_data`/`tx_valid` pins.

## Interface
- `NUM_REQ`, 2: number of requesters, ≥2.
- `MEM_WIDTH`, 8: RAM data width.
- `ADDR_SIZE`, 8: RAM address width; must equal `MEM_WIDTH` (address and data share `rx_data[7:0]`).
- `RSP_TIMEOUT`, 16: maximum WAIT cycles for `tx_valid` before an error response.
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  `NUM_REQ`  per-requester transaction request.
- `req_wr`  in  `NUM_REQ`  1 = write, 0 = read.
- `req_addr`  in  `NUM_REQ*ADDR_SIZE`  packed addresses; requester i occupies slice i.
- `req_wdata`  in  `NUM_REQ*MEM_WIDTH`  packed write data.
- `req_ready`  out  `NUM_REQ`  one-hot accept pulse; the transaction is consumed when `req_valid[i]` and `req_ready[i]` are both high.
- `rsp_valid`  out  1  one-cycle read-completion pulse.
- `rsp_id`  out  `$clog2(NUM_REQ)`  requester index owning the response.
- `rsp_data`  out  `MEM_WIDTH`  read data; 0 on error.
- `rsp_err`  out  1  read timed out; qualified by `rsp_valid`.
- `rx_data`  out  `MEM_WIDTH+2`  RAM command: {opcode[1:0], payload}.
- `rx_valid`  out  1  RAM command strobe.
- `tx_data`  in  `MEM_WIDTH`  RAM read data.
- `tx_valid`  in  1  RAM read-data valid.

## Operation
- Opcodes: 00 write-address, 01 write-data, 10 read-address, 11 read-data.
- FSM states: IDLE, ADDR, DATA, WAIT, RESP.
- IDLE, any `req_valid`:
  - round-robin grant; `req_ready[g]`=1 that cycle.
  - latch wr, addr, wdata and id; go to ADDR.
- ADDR: `rx_valid`=1, `rx_data`={wr?00:10, addr}; go to DATA.
- DATA: `rx_valid`=1, `rx_data`={wr?01:11, wr?wdata:0}. Next state is IDLE for a write, WAIT for a read (timeout counter cleared).
- WAIT:
  - `tx_valid`=1: capture `tx_data`, go to RESP.
  - Otherwise increment the counter; on reaching `RSP_TIMEOUT-1`, set the error flag, capture 0 and go to RESP.
- RESP: `rsp_valid`=1 with `rsp_id`, `rsp_data` and `rsp_err`; go to IDLE.
- Writes produce no response.
- `tx_valid` is ignored outside WAIT.
- Round-robin: priority starts at last grant + 1, wrapping. Reset sets the last grant to `NUM_REQ-1`, so requester 0 wins first. The pointer updates only on grant.
- Requests are sampled only in IDLE; `req_*` may change freely in other states.
- A requester dropping `req_valid` before grant is allowed; no state is kept for it.

## Timing
- Reset values: all outputs 0, state IDLE, last-grant = `NUM_REQ-1`, counter 0.
- `rst` mid-transaction:
  - aborts at the next edge;
  - no further `rx_valid`;
  - no `rsp_valid` for the aborted read.
- `rx_valid`, `rx_data`, `rsp_*` are registered outputs. `req_ready` is combinational from `req_valid` and state (IDLE only).
- Write, grant at cycle 0: ADDR command cycle 1, DATA command cycle 2, next grant possible cycle 3 (3 cycles per write).
- Read, grant at cycle 0: commands cycles 1–2, WAIT from cycle 3. With `tx_valid` in cycle 3+k, `rsp_valid` is in cycle 4+k. Best case 5 cycles per read.
- Timeout: no `tx_valid` across `RSP_TIMEOUT` WAIT cycles gives `rsp_valid`+`rsp_err` in cycle 3+`RSP_TIMEOUT`.
- `rx_valid` is never high on consecutive transactions without an IDLE cycle between them.

## Structure
- Package `ram_arb_pkg`:
  - opcode constants `OP_WR_ADDR`, `OP_WR_DATA`, `OP_RD_ADDR`, `OP_RD_DATA`;
  - state enum `arb_state_e`.
- Sub-module `rr_arbiter`:
  - parameter `NUM_REQ`;
  - inputs `req`, `advance`; outputs one-hot `grant`, index `grant_idx`;
  - owns the last-grant pointer.
- Top module holds the FSM, the transaction latch and the timeout counter.

## Test plan
- Reset, then req0 write addr 0x12 data 0xA5 → `req_ready`=01 in cycle 0; `rx_data`=0x012 in cycle 1 and 0x1A5 in cycle 2, each with `rx_valid`; no `rsp_valid`.
- req1 read addr 0x12, RAM returns `tx_valid` with 0xA5 in the first WAIT cycle → `rx_data` 0x212 then 0x300; `rsp_valid` with `rsp_id`=1, `rsp_data`=0xA5, `rsp_err`=0 in cycle 4.
- Both requesters hold `req_valid` for 4 transactions → grants alternate 0,1,0,1; each grant is 3 cycles apart for writes.
- Read with `tx_valid` never asserted, `RSP_TIMEOUT`=16 → `rsp_valid`, `rsp_err`=1, `rsp_data`=0 in cycle 19; IDLE next cycle.
- `rst` asserted in WAIT → all outputs 0 the next cycle; no response; next grant goes to requester 0.
- Spurious `tx_valid` during IDLE or ADDR → no `rsp_valid`; data not captured.
